aim_match_decoder: RTL and testbench

Decoder end of the associative index matcher's result interface. Takes the per-word match results (valid bit plus binary match position) produced by the matcher's encoders. Rebuilds each word's one-hot hit row over the full index array, one word per handshake. The rows stream to the downstream tracker logic, followed by a completion pulse and a hit count.

---
 rtl/aim_pkg.sv | 17 +
 rtl/aim_onehot_dec.sv | 24 ++
 rtl/aim_match_decoder.sv | 183 ++++++++++++++++++
 tb/tb_aim_match_decoder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aim_pkg.sv
// Shared constants and state encoding for the associative index matcher and its
// result decoder.
package aim_pkg;

  localparam int N_WORDS = 32;
  localparam int N_IA    = 256;
  localparam int POS_W   = 9;
  localparam int IDX_W   = $clog2(N_WORDS);
  localparam int CNT_W   = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } aim_state_e;

endpackage

// File: rtl/aim_onehot_dec.sv
// Combinational position -> one-hot row decoder with an unsigned range check
// done on the full position width.
module aim_onehot_dec #(
  parameter int POS_W = aim_pkg::POS_W,
  parameter int N_IA  = aim_pkg::N_IA
) (
  input  logic [POS_W-1:0] pos_i,
  output logic [N_IA-1:0]  row_o,
  output logic             in_range_o
);

  logic in_range_s;

  // Range check and decode; an out-of-range position yields an all-zero row.
  always_comb begin
    in_range_s = (32'(pos_i) < 32'(N_IA));
    row_o      = '0;
    for (int i = 0; i < N_IA; i++) begin
      row_o[i] = in_range_s && (32'(pos_i) == 32'(i));
    end
    in_range_o = in_range_s;
  end

endmodule

// File: rtl/aim_match_decoder.sv
// Rebuilds per-word one-hot hit rows from latched match results and streams them
// with a valid/ready handshake. Define AIM_DEC_SKIP_EN to skip words with valid=0.
module aim_match_decoder
  import aim_pkg::*;
#(
  parameter int N_WORDS = aim_pkg::N_WORDS,
  parameter int N_IA    = aim_pkg::N_IA,
  parameter int POS_W   = aim_pkg::POS_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [N_WORDS-1:0]         i_valid,
  input  logic [N_WORDS*POS_W-1:0]   i_pos,
  output logic                       o_busy,
  output logic                       o_row_valid,
  input  logic                       i_row_ready,
  output logic [$clog2(N_WORDS)-1:0] o_row_idx,
  output logic [N_IA-1:0]            o_row,
  output logic                       o_finish,
  output logic [$clog2(N_WORDS):0]   o_hit_count,
  output logic                       o_err
);

  localparam int IW = $clog2(N_WORDS);
  localparam int CW = IW + 1;

  aim_state_e               state_q;
  logic [N_WORDS-1:0]       valid_q;
  logic [N_WORDS*POS_W-1:0] pos_q;
  logic                     busy_q;
  logic                     row_valid_q;
  logic                     finish_q;
  logic                     err_q;
  logic                     row_hit_q;
  logic [IW-1:0]            row_idx_q;
  logic [N_IA-1:0]          row_q;
  logic [CW-1:0]            hit_count_q;

  logic [N_WORDS-1:0]       src_valid_s;
  logic [N_WORDS*POS_W-1:0] src_pos_s;
  logic [CW-1:0]            base_s;
  logic [IW-1:0]            ptr_d;
  logic                     found_s;
  logic                     sel_valid_s;
  logic [POS_W-1:0]         sel_pos_s;
  logic [N_IA-1:0]          dec_row_s;
  logic                     in_range_s;
  logic [N_IA-1:0]          row_d;
  logic                     row_hit_d;
  logic                     row_err_d;

  // In IDLE the first row is decoded straight from the inputs so it is ready at t+1.
  always_comb begin
    if (state_q == ST_IDLE) begin
      src_valid_s = i_valid;
      src_pos_s   = i_pos;
      base_s      = '0;
    end else begin
      src_valid_s = valid_q;
      src_pos_s   = pos_q;
      base_s      = {1'b0, row_idx_q} + CW'(1'b1);
    end
  end

`ifdef AIM_DEC_SKIP_EN
  // Next word to emit: lowest valid word at or after the search base.
  always_comb begin
    found_s = 1'b0;
    ptr_d   = '0;
    for (int i = N_WORDS - 1; i >= 0; i--) begin
      found_s = found_s | ((i >= int'(base_s)) && src_valid_s[i]);
      ptr_d   = ((i >= int'(base_s)) && src_valid_s[i]) ? IW'(i) : ptr_d;
    end
  end
`else
  // Next word to emit: every word in order.
  always_comb begin
    found_s = (32'(base_s) < 32'(N_WORDS));
    ptr_d   = base_s[IW-1:0];
  end
`endif

  // Select the word under the next pointer for the single decoder instance.
  always_comb begin
    sel_valid_s = src_valid_s[ptr_d];
    sel_pos_s   = src_pos_s[ptr_d*POS_W +: POS_W];
  end

  aim_onehot_dec #(
    .POS_W (POS_W),
    .N_IA  (N_IA)
  ) u_dec (
    .pos_i      (sel_pos_s),
    .row_o      (dec_row_s),
    .in_range_o (in_range_s)
  );

  // Row content and its hit/error classification for the next row register load.
  always_comb begin
    row_hit_d = sel_valid_s && in_range_s;
    row_err_d = sel_valid_s && !in_range_s;
    row_d     = row_hit_d ? dec_row_s : '0;
  end

  // Control FSM; all outputs come straight from these registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      valid_q     <= '0;
      pos_q       <= '0;
      busy_q      <= 1'b0;
      row_valid_q <= 1'b0;
      finish_q    <= 1'b0;
      err_q       <= 1'b0;
      row_hit_q   <= 1'b0;
      row_idx_q   <= '0;
      row_q       <= '0;
      hit_count_q <= '0;
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            valid_q     <= i_valid;
            pos_q       <= i_pos;
            busy_q      <= 1'b1;
            hit_count_q <= '0;
            state_q     <= ST_EMIT;
            row_valid_q <= found_s;
            row_idx_q   <= ptr_d;
            row_q       <= found_s ? row_d : '0;
            row_hit_q   <= row_hit_d & found_s;
            err_q       <= row_err_d & found_s;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_EMIT: begin
          if (!row_valid_q) begin
            // Nothing to emit in this batch.
            state_q  <= ST_DONE;
            finish_q <= 1'b1;
          end else if (i_row_ready) begin
            hit_count_q <= hit_count_q + CW'(row_hit_q);
            if (found_s) begin
              row_idx_q <= ptr_d;
              row_q     <= row_d;
              row_hit_q <= row_hit_d;
              err_q     <= err_q | row_err_d;
            end else begin
              row_valid_q <= 1'b0;
              row_q       <= '0;
              row_hit_q   <= 1'b0;
              state_q     <= ST_DONE;
              finish_q    <= 1'b1;
            end
          end else begin
            state_q <= ST_EMIT;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q      <= 1'b0;
          row_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_row_valid = row_valid_q;
  assign o_row_idx   = row_idx_q;
  assign o_row       = row_q;
  assign o_finish    = finish_q;
  assign o_hit_count = hit_count_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_aim_match_decoder.sv
// Scoreboard bench for aim_match_decoder: stimulus pushes expected rows, a
// negedge monitor pops and compares them on every row transfer.
module tb_aim_match_decoder;

  localparam int NW  = 32;
  localparam int NIA = 256;
  localparam int PW  = 9;
`ifdef AIM_DEC_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]     idx;
    logic [NIA-1:0] row;
  } exp_t;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_start = 1'b0;
  logic [NW-1:0]     i_valid = '0;
  logic [NW*PW-1:0]  i_pos = '0;
  logic              i_row_ready = 1'b1;
  logic              o_busy;
  logic              o_row_valid;
  logic [4:0]        o_row_idx;
  logic [NIA-1:0]    o_row;
  logic              o_finish;
  logic [5:0]        o_hit_count;
  logic              o_err;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  aim_match_decoder dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_valid     (i_valid),
    .i_pos       (i_pos),
    .o_busy      (o_busy),
    .o_row_valid (o_row_valid),
    .i_row_ready (i_row_ready),
    .o_row_idx   (o_row_idx),
    .o_row       (o_row),
    .o_finish    (o_finish),
    .o_hit_count (o_hit_count),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string nm, input logic [NIA-1:0] act, input logic [NIA-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [NIA-1:0] exp_row(input logic v, input logic [PW-1:0] p);
    logic [NIA-1:0] r;
    r = '0;
    if (v && (p < 9'd256)) r[p[7:0]] = 1'b1;
    return r;
  endfunction

  // Monitor: pops one expectation per transfer and checks stall stability.
  initial begin
    logic           stall_prev;
    logic [NIA-1:0] prev_row;
    logic [4:0]     prev_idx;
    exp_t           e;
    stall_prev = 1'b0;
    prev_row   = '0;
    prev_idx   = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", o_row_valid, 1'b1);
          check("stall_idx", o_row_idx, prev_idx);
          check("stall_row", o_row, prev_row);
        end
        if (o_row_valid && i_row_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_row_idx", o_row_idx, 5'h1f ^ o_row_idx);
          end else begin
            e = exp_q.pop_front();
            check("row_idx", o_row_idx, e.idx);
            check("row_data", o_row, e.row);
          end
        end
        stall_prev = o_row_valid && !i_row_ready;
        prev_row   = o_row;
        prev_idx   = o_row_idx;
      end
    end
  end

  task automatic run_batch(input string name, input logic [NW-1:0] v, input logic [NW*PW-1:0] p,
                           input bit stall, input bit intrude, input int exp_fin,
                           input int exp_hit, input bit exp_err);
    int         cyc;
    int         nrows;
    logic [3:0] pat;
    exp_t       e;
    pat   = 4'b1001;
    nrows = 0;
    for (int k = 0; k < NW; k++) begin
      if (!(SKIP && !v[k])) begin
        e.idx = 5'(k);
        e.row = exp_row(v[k], p[k*PW +: PW]);
        exp_q.push_back(e);
        nrows++;
      end
    end
    i_valid = v;
    i_pos = p;
    i_start = 1'b1;
    i_row_ready = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    cyc = 1;
    check({name, " busy_t1"}, o_busy, 1'b1);
    check({name, " rowvalid_t1"}, o_row_valid, nrows > 0);
    if (intrude) begin
      i_start = 1'b1;
      i_valid = ~v;
      i_pos = ~p;
    end
    while (o_finish !== 1'b1 && cyc < 300) begin
      if (stall) i_row_ready = pat[(cyc - 1) % 4];
      @(posedge i_clk); #1;
      cyc++;
      i_start = 1'b0;
    end
    check({name, " finish_seen"}, o_finish, 1'b1);
    if (exp_fin > 0) check({name, " finish_cycle"}, 32'(cyc), 32'(exp_fin));
    check({name, " rowvalid_at_finish"}, o_row_valid, 1'b0);
    check({name, " hit_count"}, o_hit_count, 6'(exp_hit));
    check({name, " err"}, o_err, exp_err);
    check({name, " rows_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    i_row_ready = 1'b1;
    @(posedge i_clk); #1;
    check({name, " busy_idle"}, o_busy, 1'b0);
    check({name, " finish_pulse"}, o_finish, 1'b0);
    check({name, " hit_held"}, o_hit_count, 6'(exp_hit));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " busy"}, o_busy, 1'b0);
    check({name, " row_valid"}, o_row_valid, 1'b0);
    check({name, " finish"}, o_finish, 1'b0);
    check({name, " err"}, o_err, 1'b0);
    check({name, " row"}, o_row, '0);
    check({name, " row_idx"}, o_row_idx, 5'd0);
    check({name, " hit_count"}, o_hit_count, 6'd0);
  endtask

  task automatic reset_mid();
    logic [NW*PW-1:0] p;
    int   cyc;
    exp_t e;
    for (int k = 0; k < NW; k++) begin
      p[k*PW +: PW] = 9'(k * 8);
      e.idx = 5'(k);
      e.row = exp_row(1'b1, 9'(k * 8));
      exp_q.push_back(e);
    end
    i_valid = '1;
    i_pos = p;
    i_start = 1'b1;
    i_row_ready = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    cyc = 0;
    while (!(o_row_valid && o_row_idx == 5'd10) && cyc < 100) begin
      @(posedge i_clk); #1;
      cyc++;
    end
    check("rst_mid reached_row10", o_row_idx, 5'd10);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    exp_q.delete();
    check_reset_vals("rst_mid");
    for (int n = 0; n < 3; n++) begin
      @(posedge i_clk); #1;
      check("rst_mid no_finish", o_finish, 1'b0);
      check("rst_mid idle", o_busy, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NW*PW-1:0] p;
    int fin33;
    fin33 = 33;

    repeat (3) @(posedge i_clk);
    #1;
    check_reset_vals("reset");
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Single hit at word 0, position 5.
    p = '0;
    p[0*PW +: PW] = 9'd5;
    run_batch("A", 32'h0000_0001, p, 1'b0, 1'b0, SKIP ? 2 : fin33, 1, 1'b0);

    // Word 3 out of range (300), word 7 at the top in-range position.
    p = '0;
    p[3*PW +: PW] = 9'd300;
    p[7*PW +: PW] = 9'd255;
    run_batch("B", 32'h0000_0088, p, 1'b0, 1'b0, SKIP ? 3 : fin33, 1, 1'b1);

    // Stalled handshake plus an ignored i_start while busy; 256 is the first bad position.
    p = '0;
    p[0*PW +: PW]  = 9'd17;
    p[1*PW +: PW]  = 9'd256;
    p[4*PW +: PW]  = 9'd100;
    p[29*PW +: PW] = 9'd200;
    p[31*PW +: PW] = 9'd255;
    run_batch("C", 32'hA000_0013, p, 1'b1, 1'b1, 0, 4, 1'b1);

    // Words 2 and 31 at positions 0 and 255.
    p = '0;
    p[2*PW +: PW]  = 9'd0;
    p[31*PW +: PW] = 9'd255;
    run_batch("D", 32'h8000_0004, p, 1'b0, 1'b0, SKIP ? 3 : fin33, 2, 1'b0);

    // All invalid; an invalid out-of-range position must not raise err.
    p = '0;
    p[5*PW +: PW] = 9'd300;
    run_batch("E", 32'h0000_0000, p, 1'b0, 1'b0, SKIP ? 2 : fin33, 0, 1'b0);

    reset_mid();

    p = '0;
    p[0*PW +: PW] = 9'd5;
    run_batch("A2", 32'h0000_0001, p, 1'b0, 1'b0, SKIP ? 2 : fin33, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
